// File: rtl/usr_sequencer.sv
// Command sequencer for a universal shift register: turns load/shift/hold
// commands into per-cycle mode selects and serial fill bits, then captures the result.
module usr_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] p_in,
    output logic             msb_in,
    output logic             lsb_in,
    input  logic [WIDTH-1:0] p_out,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        CAPTURE = 2'b10
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   remaining;
    logic [WIDTH-1:0]   fill;

    assign cmd_ready = (state == IDLE) & clear;
    assign busy      = (state != IDLE);

    // Fill bits are consumed LSB first from a shifting copy, so bits past WIDTH come out as 0.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state        <= IDLE;
            op_q         <= OP_HOLD;
            remaining    <= '0;
            fill         <= '0;
            s            <= OP_HOLD;
            p_in         <= '0;
            msb_in       <= 1'b0;
            lsb_in       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        p_in   <= cmd_data;
                        msb_in <= 1'b0;
                        lsb_in <= 1'b0;
                        s      <= OP_HOLD;
                        if (cmd_op == OP_LOAD) begin
                            state     <= RUN;
                            s         <= OP_LOAD;
                            remaining <= '0;
                        end else if (cmd_op != OP_HOLD && cmd_count != '0) begin
                            state     <= RUN;
                            s         <= cmd_op;
                            remaining <= cmd_count - CNT_W'(1);
                            fill      <= cmd_data >> 1;
                            if (cmd_op == OP_SHR) begin
                                msb_in <= cmd_data[0];
                            end else begin
                                lsb_in <= cmd_data[0];
                            end
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                RUN: begin
                    if (remaining == '0) begin
                        state  <= CAPTURE;
                        s      <= OP_HOLD;
                        msb_in <= 1'b0;
                        lsb_in <= 1'b0;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        fill      <= fill >> 1;
                        if (op_q == OP_SHR) begin
                            msb_in <= fill[0];
                        end else if (op_q == OP_SHL) begin
                            lsb_in <= fill[0];
                        end
                    end
                end
                CAPTURE: begin
                    result       <= p_out;
                    result_valid <= 1'b1;
                    p_in         <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    s     <= OP_HOLD;
                end
            endcase
        end
    end

endmodule
